// File: rtl/dense_layer_engine_pkg.sv
// rtl/dense_layer_engine_pkg.sv - shared constants, FSM states and arithmetic helpers
// Memory map defaults, accumulator sizing and output saturation for the dense layer engine.
package dense_pkg;

  localparam int DEF_ADDRESS_WIDTH = 14;
  localparam int DATA_WIDTH        = 24;
  localparam int SAT_IN_WIDTH      = 64;

  localparam logic [DEF_ADDRESS_WIDTH-1:0] DEF_X_BASE = 14'h0000;
  localparam logic [DEF_ADDRESS_WIDTH-1:0] DEF_W_BASE = 14'h0310;
  localparam logic [DEF_ADDRESS_WIDTH-1:0] DEF_B_BASE = 14'h21B0;
  localparam logic [DEF_ADDRESS_WIDTH-1:0] DEF_Y_BASE = 14'h21BA;

  localparam logic signed [SAT_IN_WIDTH-1:0] Y_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  localparam logic signed [SAT_IN_WIDTH-1:0] Y_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_B,
    ST_RD_X,
    ST_RD_W,
    ST_DRAIN,
    ST_WR_Y,
    ST_FIN
  } state_t;

  // Room for N_IN full-scale products plus the bias without wrapping.
  function automatic int acc_width(input int n_in);
    return 2 * DATA_WIDTH + $clog2(n_in + 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [SAT_IN_WIDTH-1:0] v);
    if (v > Y_MAX) begin
      return Y_MAX[DATA_WIDTH-1:0];
    end else if (v < Y_MIN) begin
      return Y_MIN[DATA_WIDTH-1:0];
    end
    return v[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dense_layer_engine_if.sv
// rtl/dense_layer_engine_if.sv - single-port data RAM bus
// The engine drives we/addr/wdata as master; the RAM returns registered rdata.
interface dense_mem_if
  import dense_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = dense_pkg::DATA_WIDTH
);
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/dense_layer_engine_argmax_tracker.sv
// rtl/dense_layer_engine_argmax_tracker.sv - running argmax over written outputs
// Strict greater-than keeps the lowest index on ties; index 0 always seeds the tracker.
module argmax_tracker
  import dense_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] value,
  input  logic [3:0]                   index,
  output logic [3:0]                   best_index
);

  logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [3:0]                   best_idx_q, best_idx_d;

  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (clear) begin
      best_val_d = '0;
      best_idx_d = '0;
    end else if (valid && ((index == 4'd0) || (value > best_val_q))) begin
      best_val_d = value;
      best_idx_d = index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_index = best_idx_q;

endmodule

// File: rtl/dense_layer_engine.sv
// rtl/dense_layer_engine.sv - fully connected layer over the shared data RAM
// Streams bias, then interleaved x/w reads per output, MACs them and writes saturated y.
module dense_layer_engine
  import dense_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = dense_pkg::DATA_WIDTH,
  parameter int N_IN          = 784,
  parameter int N_OUT         = 10,
  parameter logic [ADDRESS_WIDTH-1:0] X_BASE = DEF_X_BASE,
  parameter logic [ADDRESS_WIDTH-1:0] W_BASE = DEF_W_BASE,
  parameter logic [ADDRESS_WIDTH-1:0] B_BASE = DEF_B_BASE,
  parameter logic [ADDRESS_WIDTH-1:0] Y_BASE = DEF_Y_BASE,
  parameter int SHIFT         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  class_idx,
  dense_mem_if.master mem
);

  localparam int ACC_W  = acc_width(N_IN);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int I_W    = $clog2(N_IN + 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [3:0]     J_LAST = 4'(N_OUT - 1);

  state_t                       state_q, state_d;
  logic [I_W-1:0]               i_q, i_d;
  logic [3:0]                   j_q, j_d;
  logic [ADDRESS_WIDTH-1:0]     w_ptr_q, w_ptr_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [3:0]                   class_q, class_d;

  logic signed [DATA_WIDTH-1:0] rdata_s;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      prod_ext, bias_ext, shifted;
  logic [DATA_WIDTH-1:0]        y;
  logic                         trk_clear, trk_valid;
  logic [3:0]                   best_idx;

  assign rdata_s  = $signed(mem.mem_rdata);
  assign prod     = x_q * rdata_s;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W - DATA_WIDTH){rdata_s[DATA_WIDTH-1]}}, rdata_s};
  assign shifted  = acc_q >>> SHIFT;
  assign y        = saturate({{(SAT_IN_WIDTH - ACC_W){shifted[ACC_W-1]}}, shifted});

  // Address/we outputs decode straight from state so reset removes mem_we immediately.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    w_ptr_d       = w_ptr_q;
    x_d           = x_q;
    acc_d         = acc_q;
    class_d       = class_q;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    busy          = 1'b1;
    done          = 1'b0;
    trk_clear     = 1'b0;
    trk_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = ST_RD_B;
          j_d       = '0;
          w_ptr_d   = W_BASE;
          trk_clear = 1'b1;
        end
      end
      ST_RD_B: begin
        mem.mem_addr = B_BASE + ADDRESS_WIDTH'(j_q);
        i_d          = '0;
        state_d      = ST_RD_X;
      end
      ST_RD_X: begin
        // The first x read overlaps the bias returning; later ones overlap a weight returning.
        mem.mem_addr = X_BASE + ADDRESS_WIDTH'(i_q);
        acc_d        = (i_q == '0) ? bias_ext : acc_q + prod_ext;
        state_d      = ST_RD_W;
      end
      ST_RD_W: begin
        mem.mem_addr = w_ptr_q;
        w_ptr_d      = w_ptr_q + ADDRESS_WIDTH'(1);
        x_d          = rdata_s;
        if (i_q == I_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          i_d     = i_q + I_W'(1);
          state_d = ST_RD_X;
        end
      end
      ST_DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = ST_WR_Y;
      end
      ST_WR_Y: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = Y_BASE + ADDRESS_WIDTH'(j_q);
        mem.mem_wdata = y;
        trk_valid     = 1'b1;
        if (j_q == J_LAST) begin
          state_d = ST_FIN;
        end else begin
          j_d     = j_q + 4'd1;
          state_d = ST_RD_B;
        end
      end
      ST_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        class_d = best_idx;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      w_ptr_q <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      w_ptr_q <= w_ptr_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      class_q <= class_d;
    end
  end

  argmax_tracker u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear      (trk_clear),
    .valid      (trk_valid),
    .value      ($signed(y)),
    .index      (j_q),
    .best_index (best_idx)
  );

  assign class_idx = class_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// tb/tb_dense_layer_engine.sv - directed bench for dense_layer_engine
// Three engines share one clock: 2x2 hand case, 1x3 saturation/tie case, full default size.
module tb_dense_layer_engine;
  import dense_pkg::*;

  localparam int XB = 'h0000;
  localparam int WB = 'h0310;
  localparam int BB = 'h21B0;
  localparam int YB = 'h21BA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;
  wire  [2:0] busy_v, done_v, we_v;
  wire  [3:0] cls_v [0:2];

  logic        ld_en;
  logic [1:0]  ld_sel;
  logic [13:0] ld_addr;
  logic [23:0] ld_data;

  logic [23:0] mem0 [0:16383];
  logic [23:0] mem1 [0:16383];
  logic [23:0] mem2 [0:16383];

  int vectors = 0;
  int miscompares = 0;

  dense_mem_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(24)) m0 ();
  dense_mem_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(24)) m1 ();
  dense_mem_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(24)) m2 ();

  assign we_v = {m2.mem_we, m1.mem_we, m0.mem_we};

  dense_layer_engine #(.N_IN(2), .N_OUT(2), .SHIFT(0)) dut_small (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .class_idx(cls_v[0]), .mem(m0)
  );
  dense_layer_engine #(.N_IN(1), .N_OUT(3), .SHIFT(0)) dut_tiny (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .class_idx(cls_v[1]), .mem(m1)
  );
  dense_layer_engine dut_full (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .class_idx(cls_v[2]), .mem(m2)
  );

  always @(posedge clk) begin
    if (ld_en && ld_sel == 2'd0) mem0[ld_addr] <= ld_data;
    else if (m0.mem_we) mem0[m0.mem_addr] <= m0.mem_wdata;
    m0.mem_rdata <= mem0[m0.mem_addr];
  end
  always @(posedge clk) begin
    if (ld_en && ld_sel == 2'd1) mem1[ld_addr] <= ld_data;
    else if (m1.mem_we) mem1[m1.mem_addr] <= m1.mem_wdata;
    m1.mem_rdata <= mem1[m1.mem_addr];
  end
  always @(posedge clk) begin
    if (ld_en && ld_sel == 2'd2) mem2[ld_addr] <= ld_data;
    else if (m2.mem_we) mem2[m2.mem_addr] <= m2.mem_wdata;
    m2.mem_rdata <= mem2[m2.mem_addr];
  end

  function automatic logic [23:0] s24(input int v);
    return v[23:0];
  endfunction

  function automatic int xfun(input int i);
    return ((i * 37) % 255) - 127;
  endfunction
  function automatic int wfun(input int k);
    return ((k * 53 + 11) % 201) - 100;
  endfunction
  function automatic int bfun(input int j);
    return j * 1000 - 4000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int sel, input int a, input int v);
    ld_en   = 1'b1;
    ld_sel  = sel[1:0];
    ld_addr = a[13:0];
    ld_data = s24(v);
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic run(input int sel, input bit hold, output int busy_n, output int done_n,
                     output int we_n);
    busy_n = 0;
    done_n = 0;
    we_n   = 0;
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
    for (int c = 0; c < 20000 && done_n == 0; c++) begin
      if (busy_v[sel]) busy_n++;
      if (we_v[sel]) we_n++;
      if (done_v[sel]) done_n++;
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      for (int c = 0; c < 3; c++) begin
        if (done_v[sel]) done_n++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [23:0] exp_y [0:9];

  initial begin
    int bn, dn, wn, exp_cls;
    longint acc, sh, best;

    rst = 1'b1;
    start_v = '0;
    ld_en = 1'b0;
    ld_sel = '0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_v[0], 0);
    chk("reset_done", done_v[0], 0);
    chk("reset_we", m0.mem_we, 0);
    chk("reset_addr", m0.mem_addr, 0);
    chk("reset_wdata", m0.mem_wdata, 0);
    chk("reset_class", cls_v[0], 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2x2 hand case: y0 = 3*1 - 2*2 + 10 = 9, y1 = 3*4 - 2*5 - 1 = 1
    load(0, XB, 3);  load(0, XB + 1, -2);
    load(0, WB, 1);  load(0, WB + 1, 2);  load(0, WB + 2, 4);  load(0, WB + 3, 5);
    load(0, BB, 10); load(0, BB + 1, -1);
    run(0, 0, bn, dn, wn);
    chk("small_busy_cycles", bn, 14);
    chk("small_done_pulses", dn, 1);
    chk("small_we_cycles", wn, 2);
    chk("small_y0", mem0[YB], s24(9));
    chk("small_y1", mem0[YB + 1], s24(1));
    chk("small_class", cls_v[0], 0);

    // Saturation: positive overflow, negative overflow, and exactly 2^23
    load(1, XB, 'h7FFFFF);
    load(1, WB, 'h7FFFFF); load(1, WB + 1, -8388608); load(1, WB + 2, 1);
    load(1, BB, 0);        load(1, BB + 1, 0);        load(1, BB + 2, 1);
    run(1, 0, bn, dn, wn);
    chk("sat_busy_cycles", bn, 15);
    chk("sat_y0_pos", mem1[YB], 24'h7FFFFF);
    chk("sat_y1_neg", mem1[YB + 1], 24'h800000);
    chk("sat_y2_edge", mem1[YB + 2], 24'h7FFFFF);
    chk("sat_class_tie", cls_v[1], 0);

    load(1, XB, 1);
    load(1, WB, 0); load(1, WB + 1, 0); load(1, WB + 2, 0);
    load(1, BB, 5); load(1, BB + 1, 5); load(1, BB + 2, 5);
    run(1, 0, bn, dn, wn);
    chk("tie_all5_y2", mem1[YB + 2], s24(5));
    chk("tie_all5_class", cls_v[1], 0);

    load(1, BB, -3); load(1, BB + 1, 7); load(1, BB + 2, 7);
    run(1, 0, bn, dn, wn);
    chk("tie_m3_y0", mem1[YB], s24(-3));
    chk("tie_m3_class", cls_v[1], 1);

    // Reset during the first Y write of a run
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    for (int c = 0; c < 50 && !we_v[1]; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_reached_write", we_v[1], 1);
    rst = 1'b1;
    #1;
    chk("rst_we_async", we_v[1], 0);
    chk("rst_idle", busy_v[1], 0);
    chk("rst_class", cls_v[1], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    bn = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_v[1]) dn++;
      if (busy_v[1]) bn++;
      @(posedge clk);
      #1;
    end
    chk("rst_no_done", dn, 0);
    chk("rst_stays_idle", bn, 0);
    run(1, 0, bn, dn, wn);
    chk("rerun_done", dn, 1);
    chk("rerun_busy_cycles", bn, 15);
    chk("rerun_class", cls_v[1], 1);

    // start held high: y0 = 3 - 4 - 1 = -2, y1 = 12 - 10 + 10 = 12
    load(0, BB, -1); load(0, BB + 1, 10);
    run(0, 1, bn, dn, wn);
    chk("hold_first_done", dn, 1);
    chk("hold_first_busy", bn, 14);
    chk("hold_idle_after_done", busy_v[0], 0);
    @(posedge clk);
    #1;
    chk("hold_second_starts", busy_v[0], 1);
    start_v[0] = 1'b0;
    dn = 0;
    for (int c = 0; c < 100 && dn == 0; c++) begin
      if (done_v[0]) dn++;
      @(posedge clk);
      #1;
    end
    chk("hold_second_done", dn, 1);
    chk("hold_class", cls_v[0], 1);
    chk("hold_y0", mem0[YB], s24(-2));
    chk("hold_y1", mem0[YB + 1], s24(12));
    bn = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy_v[0]) bn++;
      @(posedge clk);
      #1;
    end
    chk("hold_no_third_run", bn, 0);

    // Full default size against a software model
    for (int i = 0; i < 784; i++) load(2, XB + i, xfun(i));
    for (int k = 0; k < 7840; k++) load(2, WB + k, wfun(k));
    for (int j = 0; j < 10; j++) load(2, BB + j, bfun(j));
    exp_cls = 0;
    best = 0;
    for (int j = 0; j < 10; j++) begin
      acc = longint'(bfun(j));
      for (int i = 0; i < 784; i++) acc += longint'(xfun(i)) * longint'(wfun(j * 784 + i));
      sh = acc >>> 8;
      if (sh > 64'sd8388607) sh = 64'sd8388607;
      if (sh < -64'sd8388608) sh = -64'sd8388608;
      exp_y[j] = sh[23:0];
      if (j == 0 || sh > best) begin
        best = sh;
        exp_cls = j;
      end
    end
    run(2, 0, bn, dn, wn);
    chk("full_busy_cycles", bn, 15710);
    chk("full_done_pulses", dn, 1);
    chk("full_we_cycles", wn, 10);
    for (int j = 0; j < 10; j++) chk($sformatf("full_y%0d", j), mem2[YB + j], exp_y[j]);
    chk("full_class", cls_v[2], exp_cls);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
